// File: rtl/variable_update_unit.sv
// Purpose: owns the MCMC assignment (boolean bits + clamped signed integers); turns a chosen variable into a proposal and commits it on accept.
// Latency: proposal valid 1 cycle after the choice handshake; register file and out_commit update 1 cycle after an accepting decision.
// Backpressure: out_choice_ready is low while a proposal waits for its decision; choices are only taken in IDLE.
module variable_update_unit #(
    parameter int NUM_BOOLEAN_VARIABLES = 2,
    parameter int NUM_INTEGER_VARIABLES = 3,
    parameter int INDEX_WIDTH           = 4,
    parameter int INT_WIDTH             = 8,
    parameter int INT_MIN               = -128,
    parameter int INT_MAX               = 127,
    parameter int INT_INIT              = 0
) (
    input  logic                                       in_clock,
    input  logic                                       in_reset,
    input  logic                                       in_choice_valid,
    output logic                                       out_choice_ready,
    input  logic                                       in_boolean_or_integer,
    input  logic [INDEX_WIDTH-1:0]                     in_choosen_index,
    input  logic [INT_WIDTH-1:0]                       in_delta,
    output logic                                       out_proposal_valid,
    output logic                                       out_proposal_boolean_or_integer,
    output logic [INDEX_WIDTH-1:0]                     out_proposal_index,
    output logic [INT_WIDTH-1:0]                       out_old_value,
    output logic [INT_WIDTH-1:0]                       out_new_value,
    input  logic                                       in_decision_valid,
    input  logic                                       in_accept,
    output logic                                       out_commit,
    output logic                                       out_index_error,
    output logic [NUM_BOOLEAN_VARIABLES-1:0]           out_boolean_values,
    output logic [NUM_INTEGER_VARIABLES*INT_WIDTH-1:0] out_integer_values,
    output logic [15:0]                                out_accept_count,
    output logic [15:0]                                out_reject_count
);

    typedef enum logic {IDLE, PROPOSE} state_t;

    // Clamp bounds widened by one bit so the unclamped sum never overflows.
    localparam logic signed [INT_WIDTH:0] MAX_X  = (INT_WIDTH+1)'(INT_MAX);
    localparam logic signed [INT_WIDTH:0] MIN_X  = (INT_WIDTH+1)'(INT_MIN);
    localparam logic [INT_WIDTH-1:0]      INIT_V = INT_WIDTH'(INT_INIT);

    state_t                                 state_q, state_d;
    logic [NUM_BOOLEAN_VARIABLES-1:0]       bool_q;
    logic [NUM_INTEGER_VARIABLES*INT_WIDTH-1:0] int_q;
    logic                                   prop_type_q;
    logic [INDEX_WIDTH-1:0]                 prop_index_q;
    logic [INT_WIDTH-1:0]                   prop_old_q, prop_new_q;
    logic                                   commit_q, index_error_q;
    logic [15:0]                            accept_cnt_q, reject_cnt_q;

    logic                                   choice_in_range;
    logic                                   cur_bool;
    logic [INT_WIDTH-1:0]                   cur_int;
    logic signed [INT_WIDTH:0]              sum;
    logic [INT_WIDTH-1:0]                   old_value, new_value;
    logic                                   choice_fire, decision_fire;

    // Look up the chosen variable and build the proposal from the current register file.
    always_comb begin
        cur_bool  = 1'b0;
        cur_int   = '0;
        old_value = '0;
        new_value = '0;
        for (int i = 0; i < NUM_BOOLEAN_VARIABLES; i++)
            if (int'(in_choosen_index) == i) cur_bool = bool_q[i];
        for (int i = 0; i < NUM_INTEGER_VARIABLES; i++)
            if (int'(in_choosen_index) == i) cur_int = int_q[i*INT_WIDTH +: INT_WIDTH];
        choice_in_range = in_boolean_or_integer ?
                          (int'(in_choosen_index) < NUM_BOOLEAN_VARIABLES) :
                          (int'(in_choosen_index) < NUM_INTEGER_VARIABLES);
        sum = $signed({cur_int[INT_WIDTH-1], cur_int}) + $signed({in_delta[INT_WIDTH-1], in_delta});
        if (in_boolean_or_integer) begin
            old_value = {{(INT_WIDTH-1){1'b0}}, cur_bool};
            new_value = {{(INT_WIDTH-1){1'b0}}, ~cur_bool};
        end else begin
            old_value = cur_int;
            if (sum > MAX_X)      new_value = MAX_X[INT_WIDTH-1:0];
            else if (sum < MIN_X) new_value = MIN_X[INT_WIDTH-1:0];
            else                  new_value = sum[INT_WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge in_clock) begin
        if (in_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and handshake strobes.
    always_comb begin
        state_d          = state_q;
        out_choice_ready = 1'b0;
        choice_fire      = 1'b0;
        decision_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                out_choice_ready = 1'b1;
                choice_fire      = in_choice_valid;
                if (in_choice_valid && choice_in_range) state_d = PROPOSE;
            end
            PROPOSE: begin
                decision_fire = in_decision_valid;
                if (in_decision_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Proposal latch, register-file commit, pulses and decision counters.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            bool_q        <= '0;
            for (int i = 0; i < NUM_INTEGER_VARIABLES; i++)
                int_q[i*INT_WIDTH +: INT_WIDTH] <= INIT_V;
            prop_type_q   <= 1'b0;
            prop_index_q  <= '0;
            prop_old_q    <= '0;
            prop_new_q    <= '0;
            commit_q      <= 1'b0;
            index_error_q <= 1'b0;
            accept_cnt_q  <= '0;
            reject_cnt_q  <= '0;
        end else begin
            commit_q      <= 1'b0;
            index_error_q <= 1'b0;
            if (choice_fire) begin
                if (choice_in_range) begin
                    prop_type_q  <= in_boolean_or_integer;
                    prop_index_q <= in_choosen_index;
                    prop_old_q   <= old_value;
                    prop_new_q   <= new_value;
                end else begin
                    index_error_q <= 1'b1;
                end
            end
            if (decision_fire) begin
                if (in_accept) begin
                    for (int i = 0; i < NUM_BOOLEAN_VARIABLES; i++)
                        if (prop_type_q && int'(prop_index_q) == i) bool_q[i] <= prop_new_q[0];
                    for (int i = 0; i < NUM_INTEGER_VARIABLES; i++)
                        if (!prop_type_q && int'(prop_index_q) == i)
                            int_q[i*INT_WIDTH +: INT_WIDTH] <= prop_new_q;
                    commit_q     <= 1'b1;
                    accept_cnt_q <= accept_cnt_q + 16'd1;
                end else begin
                    reject_cnt_q <= reject_cnt_q + 16'd1;
                end
                prop_type_q  <= 1'b0;
                prop_index_q <= '0;
                prop_old_q   <= '0;
                prop_new_q   <= '0;
            end
        end
    end

    assign out_proposal_valid              = (state_q == PROPOSE);
    assign out_proposal_boolean_or_integer = prop_type_q;
    assign out_proposal_index              = prop_index_q;
    assign out_old_value                   = prop_old_q;
    assign out_new_value                   = prop_new_q;
    assign out_commit                      = commit_q;
    assign out_index_error                 = index_error_q;
    assign out_boolean_values              = bool_q;
    assign out_integer_values              = int_q;
    assign out_accept_count                = accept_cnt_q;
    assign out_reject_count                = reject_cnt_q;

endmodule
